cc_capture_sched: RTL and testbench

Capture scheduler for the CMOS capture path. Sequences the capture host's single-shot arm input to grab N frames after skipping K frames. Watches vsync for progress, samples the host's per-frame length/bit statistics after each captured frame, and enforces a frame-timeout watchdog. It sits between the control/register interface and the capture host, in the cmos_clk_i domain.

---
 rtl/cc_sched_pkg.sv | 31 +++
 rtl/cc_sched_watchdog.sv | 33 +++
 rtl/cc_capture_sched.sv | 234 +++++++++++++++++++++++
 tb/tb_cc_capture_sched.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cc_sched_pkg.sv
// Shared types and constants for the CMOS capture scheduler.
// The optional statistics block is enabled by defining CC_SCHED_STATS_EN.
package cc_sched_pkg;

  localparam int CNT_W_DEF  = 16;
  localparam int SKIP_W_DEF = 8;
  localparam int TMO_W_DEF  = 32;

  typedef enum logic [7:0] {
    ST_IDLE     = 8'b0000_0001,
    ST_SKIP     = 8'b0000_0010,
    ST_ARM      = 8'b0000_0100,
    ST_WAIT_SOF = 8'b0000_1000,
    ST_CAPTURE  = 8'b0001_0000,
    ST_STAT     = 8'b0010_0000,
    ST_DONE     = 8'b0100_0000,
    ST_ERR      = 8'b1000_0000
  } state_e;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_TMO   = 2'd1;
  localparam logic [1:0] ERR_ABORT = 2'd2;
  localparam logic [1:0] ERR_EMPTY = 2'd3;

  function automatic logic [47:0] sat_add48(input logic [47:0] a, input logic [31:0] b);
    logic [48:0] sum;
    sum = {1'b0, a} + {17'd0, b};
    return sum[48] ? {48{1'b1}} : sum[47:0];
  endfunction

endpackage

// File: rtl/cc_sched_watchdog.sv
// Frame-timeout watchdog: saturating cycle counter compared against a limit.
// A limit of zero disables expiry.
module cc_sched_watchdog
  import cc_sched_pkg::*;
#(
  parameter int TMO_W = TMO_W_DEF
) (
  input  logic             cmos_clk_i,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [TMO_W-1:0] timeout,
  output logic             expired
);

  logic [TMO_W-1:0] cnt_r;

  // cycle counter: clear wins, otherwise count while enabled and hold at all-ones
  always_ff @(posedge cmos_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en && (cnt_r != {TMO_W{1'b1}})) begin
      cnt_r <= cnt_r + TMO_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = (timeout != '0) && (cnt_r == timeout);

endmodule

// File: rtl/cc_capture_sched.sv
// Capture scheduler: skips K frames, then arms the capture host for N frames,
// collecting per-frame statistics. Optional totals via CC_SCHED_STATS_EN.
module cc_capture_sched
  import cc_sched_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int SKIP_W = SKIP_W_DEF,
  parameter int TMO_W  = TMO_W_DEF
) (
  input  logic              cmos_clk_i,
  input  logic              rst_n,
  input  logic              cmos_vsync_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [CNT_W-1:0]  frames_i,
  input  logic [SKIP_W-1:0] skip_i,
  input  logic [TMO_W-1:0]  timeout_i,
  input  logic [31:0]       frame_length_i,
  input  logic [31:0]       bits_per_frame_i,
  output logic              arm_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [1:0]        err_code_o,
  output logic [CNT_W-1:0]  frames_done_o,
  output logic [31:0]       last_len_o,
  output logic [31:0]       last_bits_o
`ifdef CC_SCHED_STATS_EN
  ,
  output logic [47:0]       total_bits_o,
  output logic [31:0]       max_len_o,
  output logic [31:0]       min_len_o
`endif
);

  state_e            state_r, state_next_s;
  logic              vsync_q_r;
  logic              vsync_rise_s;
  logic [CNT_W-1:0]  frames_r, frames_done_r;
  logic [SKIP_W-1:0] skip_cnt_r;
  logic [TMO_W-1:0]  tmo_r;
  logic [31:0]       last_len_r, last_bits_r;
  logic              error_r;
  logic [1:0]        err_code_r;
  logic              arm_r, done_r, busy_r;
  logic              start_ok_s, stat_upd_s, skip_dec_s, err_set_s;
  logic [1:0]        err_code_s;
  logic              wd_clr_s, wd_en_s, wd_expired_s;
  logic              last_frame_s;

  assign vsync_rise_s = cmos_vsync_i & ~vsync_q_r;
  // widened compare so frames_done+1 cannot wrap onto a small frames value
  assign last_frame_s = (({1'b0, frames_done_r} + (CNT_W+1)'(1)) == {1'b0, frames_r});

  cc_sched_watchdog #(.TMO_W(TMO_W)) u_watchdog (
    .cmos_clk_i (cmos_clk_i),
    .rst_n      (rst_n),
    .clr        (wd_clr_s),
    .en         (wd_en_s),
    .timeout    (tmo_r),
    .expired    (wd_expired_s)
  );

  assign wd_en_s  = (state_r == ST_SKIP) || (state_r == ST_WAIT_SOF) || (state_r == ST_CAPTURE);
  assign wd_clr_s = vsync_rise_s ||
                    (((state_next_s == ST_SKIP) || (state_next_s == ST_WAIT_SOF)) &&
                     (state_next_s != state_r));

  // next-state and per-cycle action decode; abort outranks every other event
  always_comb begin
    state_next_s = state_r;
    start_ok_s   = 1'b0;
    stat_upd_s   = 1'b0;
    skip_dec_s   = 1'b0;
    err_set_s    = 1'b0;
    err_code_s   = ERR_NONE;
    if (abort_i && (state_r != ST_IDLE) && (state_r != ST_ERR)) begin
      state_next_s = ST_ERR;
      err_set_s    = 1'b1;
      err_code_s   = ERR_ABORT;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_i && !abort_i) begin
            start_ok_s = 1'b1;
            if (frames_i == '0) begin
              state_next_s = ST_DONE;
            end else if (skip_i != '0) begin
              state_next_s = ST_SKIP;
            end else begin
              state_next_s = ST_ARM;
            end
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_SKIP: begin
          if (vsync_rise_s) begin
            skip_dec_s = 1'b1;
            if (skip_cnt_r == SKIP_W'(1)) begin
              state_next_s = ST_ARM;
            end else begin
              state_next_s = ST_SKIP;
            end
          end else if (wd_expired_s) begin
            state_next_s = ST_ERR;
            err_set_s    = 1'b1;
            err_code_s   = ERR_TMO;
          end else begin
            state_next_s = ST_SKIP;
          end
        end
        ST_ARM: state_next_s = ST_WAIT_SOF;
        ST_WAIT_SOF, ST_CAPTURE: begin
          if (vsync_rise_s) begin
            state_next_s = (state_r == ST_WAIT_SOF) ? ST_CAPTURE : ST_STAT;
          end else if (wd_expired_s) begin
            state_next_s = ST_ERR;
            err_set_s    = 1'b1;
            err_code_s   = ERR_TMO;
          end else begin
            state_next_s = state_r;
          end
        end
        ST_STAT: begin
          stat_upd_s = 1'b1;
          if (bits_per_frame_i == 32'd0) begin
            state_next_s = ST_ERR;
            err_set_s    = 1'b1;
            err_code_s   = ERR_EMPTY;
          end else if (last_frame_s) begin
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_ARM;
          end
        end
        ST_DONE: state_next_s = ST_IDLE;
        ST_ERR:  state_next_s = ST_IDLE;
        default: state_next_s = ST_IDLE;
      endcase
    end
  end

  // state register, vsync edge history and registered strobes
  always_ff @(posedge cmos_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      vsync_q_r <= 1'b0;
      arm_r     <= 1'b0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      vsync_q_r <= cmos_vsync_i;
      arm_r     <= (state_next_s == ST_ARM);
      done_r    <= (state_next_s == ST_DONE);
      busy_r    <= (state_next_s != ST_IDLE);
    end
  end

  // job parameters, progress counters, frame statistics and sticky error
  always_ff @(posedge cmos_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      frames_r      <= '0;
      skip_cnt_r    <= '0;
      tmo_r         <= '0;
      frames_done_r <= '0;
      last_len_r    <= 32'd0;
      last_bits_r   <= 32'd0;
      error_r       <= 1'b0;
      err_code_r    <= ERR_NONE;
    end else if (start_ok_s) begin
      frames_r      <= frames_i;
      skip_cnt_r    <= skip_i;
      tmo_r         <= timeout_i;
      frames_done_r <= '0;
      error_r       <= 1'b0;
      err_code_r    <= ERR_NONE;
    end else begin
      if (skip_dec_s) begin
        skip_cnt_r <= skip_cnt_r - SKIP_W'(1);
      end
      if (stat_upd_s) begin
        last_len_r  <= frame_length_i;
        last_bits_r <= bits_per_frame_i;
        if (frames_done_r != {CNT_W{1'b1}}) begin
          frames_done_r <= frames_done_r + CNT_W'(1);
        end
      end
      if (err_set_s) begin
        error_r    <= 1'b1;
        err_code_r <= err_code_s;
      end
    end
  end

  assign arm_o         = arm_r;
  assign done_o        = done_r;
  assign busy_o        = busy_r;
  assign error_o       = error_r;
  assign err_code_o    = err_code_r;
  assign frames_done_o = frames_done_r;
  assign last_len_o    = last_len_r;
  assign last_bits_o   = last_bits_r;

`ifdef CC_SCHED_STATS_EN
  logic [47:0] total_bits_r;
  logic [31:0] max_len_r, min_len_r;

  // per-job totals, updated alongside the last-frame statistics
  always_ff @(posedge cmos_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      total_bits_r <= 48'd0;
      max_len_r    <= 32'd0;
      min_len_r    <= 32'd0;
    end else if (start_ok_s) begin
      total_bits_r <= 48'd0;
      max_len_r    <= 32'd0;
      min_len_r    <= 32'hFFFF_FFFF;
    end else if (stat_upd_s) begin
      total_bits_r <= sat_add48(total_bits_r, bits_per_frame_i);
      max_len_r    <= (frame_length_i > max_len_r) ? frame_length_i : max_len_r;
      min_len_r    <= (frame_length_i < min_len_r) ? frame_length_i : min_len_r;
    end else begin
      total_bits_r <= total_bits_r;
    end
  end

  assign total_bits_o = total_bits_r;
  assign max_len_o    = max_len_r;
  assign min_len_o    = min_len_r;
`endif

endmodule

// File: tb/tb_cc_capture_sched.sv
// Randomized bench for cc_capture_sched against an event-level job model.
// Edge k is the k-th rising clock edge; outputs are observed on the next falling edge.
`timescale 1ns/1ps
module tb_cc_capture_sched;

  logic        cmos_clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmos_vsync_i = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [15:0] frames_i = 16'd0;
  logic [7:0]  skip_i = 8'd0;
  logic [31:0] timeout_i = 32'd0;
  logic [31:0] frame_length_i = 32'd0;
  logic [31:0] bits_per_frame_i = 32'd0;
  logic        arm_o, busy_o, done_o, error_o;
  logic [1:0]  err_code_o;
  logic [15:0] frames_done_o;
  logic [31:0] last_len_o, last_bits_o;
`ifdef CC_SCHED_STATS_EN
  logic [47:0] total_bits_o;
  logic [31:0] max_len_o, min_len_o;
`endif

  always #5 cmos_clk_i = ~cmos_clk_i;

  cc_capture_sched dut (
    .cmos_clk_i(cmos_clk_i), .rst_n(rst_n), .cmos_vsync_i(cmos_vsync_i),
    .start_i(start_i), .abort_i(abort_i), .frames_i(frames_i), .skip_i(skip_i),
    .timeout_i(timeout_i), .frame_length_i(frame_length_i),
    .bits_per_frame_i(bits_per_frame_i), .arm_o(arm_o), .busy_o(busy_o),
    .done_o(done_o), .error_o(error_o), .err_code_o(err_code_o),
    .frames_done_o(frames_done_o), .last_len_o(last_len_o), .last_bits_o(last_bits_o)
`ifdef CC_SCHED_STATS_EN
    , .total_bits_o(total_bits_o), .max_len_o(max_len_o), .min_len_o(min_len_o)
`endif
  );

  int checks = 0;
  int failures = 0;
  int n = 0;

  int          rise_q[$];
  logic [31:0] len_q[$], bits_q[$];
  int          exp_arm[$], obs_arm[$], obs_done[$];
  int          st_edge[$];
  logic [31:0] st_len[$], st_bits[$];
  int          f_edge, last_ev;
  bit          f_err, hang;
  logic [1:0]  f_code;
  logic [31:0] m_last_len = 32'd0, m_last_bits = 32'd0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: observed %0h expected %0h (edge %0d)", tag, act, exp, n);
    end
  endtask

  task automatic tick();
    @(negedge cmos_clk_i);
    n++;
  endtask

  function automatic int rise_idx(input int k);
    foreach (rise_q[i]) if (rise_q[i] == k) return i;
    return -1;
  endfunction

  function automatic bit vsync_at(input int k);
    foreach (rise_q[i]) if (k >= rise_q[i] && k <= rise_q[i] + 2) return 1'b1;
    return 1'b0;
  endfunction

  // first vsync rise after 'after', unless the watchdog (cleared at c) fires first
  task automatic next_rise(input int after, input int c, input int t, output int ev,
                           output int idx, output bit tmo, output bit none);
    idx = -1;
    foreach (rise_q[i]) if (idx < 0 && rise_q[i] > after) idx = i;
    ev = (idx < 0) ? -1 : rise_q[idx];
    tmo = 1'b0;
    none = 1'b0;
    if (t != 0 && (idx < 0 || ev > c + t + 1)) begin
      tmo = 1'b1;
      ev = c + t + 1;
    end else if (idx < 0) begin
      none = 1'b1;
    end
  endtask

  // event-level prediction of one job without abort
  task automatic predict(input int t0, input int k_skip, input int n_fr, input int t);
    int pos, s, e, idx, j, armk;
    bit tm, nn;
    exp_arm.delete(); st_edge.delete(); st_len.delete(); st_bits.delete();
    hang = 1'b0; f_err = 1'b0; f_code = 2'd0; f_edge = t0; last_ev = t0;
    if (n_fr == 0) return;
    pos = t0;
    for (int k = 0; k < k_skip; k++) begin
      next_rise(pos, pos, t, e, idx, tm, nn);
      if (nn) begin hang = 1'b1; last_ev = pos; return; end
      if (tm) begin f_edge = e; f_err = 1'b1; f_code = 2'd1; return; end
      pos = e;
    end
    armk = pos;
    j = 0;
    while (j < n_fr) begin
      exp_arm.push_back(armk);
      next_rise(armk + 1, armk + 1, t, s, idx, tm, nn);
      if (nn) begin hang = 1'b1; last_ev = armk + 1; return; end
      if (tm) begin f_edge = s; f_err = 1'b1; f_code = 2'd1; return; end
      next_rise(s, s, t, e, idx, tm, nn);
      if (nn) begin hang = 1'b1; last_ev = s; return; end
      if (tm) begin f_edge = e; f_err = 1'b1; f_code = 2'd1; return; end
      st_edge.push_back(e + 1); st_len.push_back(len_q[idx]); st_bits.push_back(bits_q[idx]);
      j++;
      if (bits_q[idx] == 32'd0) begin f_edge = e + 1; f_err = 1'b1; f_code = 2'd3; return; end
      if (j == n_fr) begin f_edge = e + 1; return; end
      armk = e + 1;
    end
  endtask

  task automatic run_job();
    int k_skip, n_fr, t, t0, total, r, a, bs, endk, ri, ns;
    int keep_arm[$];
    logic [47:0] m_tot;
    logic [31:0] m_max, m_min;
    k_skip = $urandom_range(0, 3);
    n_fr   = $urandom_range(0, 4);
    t      = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(30, 120);
    t0     = n + 1;
    total  = k_skip + 2 * n_fr + 1;
    if ($urandom_range(0, 3) == 0) total = $urandom_range(0, k_skip + 2 * n_fr);
    rise_q.delete(); len_q.delete(); bits_q.delete();
    r = t0 + $urandom_range(2, 30);
    for (int i = 0; i < total; i++) begin
      rise_q.push_back(r);
      len_q.push_back($urandom_range(1, 32'h00FF_FFFF));
      bits_q.push_back(($urandom_range(0, 9) == 0) ? 32'd0 : ($urandom | 32'd1));
      r += $urandom_range(8, 60);
    end
    predict(t0, k_skip, n_fr, t);
    a = 0;
    if (hang) a = last_ev + 20 + $urandom_range(0, 19);
    else if (f_edge > t0 && $urandom_range(0, 3) == 0) a = $urandom_range(t0 + 1, f_edge);
    if (a != 0) begin
      f_edge = a; f_err = 1'b1; f_code = 2'd2;
      keep_arm.delete();
      foreach (exp_arm[i]) if (exp_arm[i] < a) keep_arm.push_back(exp_arm[i]);
      exp_arm = keep_arm;
      while (st_edge.size() > 0 && st_edge[st_edge.size()-1] >= a) begin
        void'(st_edge.pop_back()); void'(st_len.pop_back()); void'(st_bits.pop_back());
      end
    end
    bs = ($urandom_range(0, 1) == 1) ? $urandom_range(t0 + 1, f_edge + 1) : -1;
    ns = st_edge.size();
    if (ns > 0) begin m_last_len = st_len[ns-1]; m_last_bits = st_bits[ns-1]; end
    m_tot = 48'd0; m_max = 32'd0; m_min = 32'hFFFF_FFFF;
    foreach (st_bits[i]) begin
      m_tot += {16'd0, st_bits[i]};
      if (st_len[i] > m_max) m_max = st_len[i];
      if (st_len[i] < m_min) m_min = st_len[i];
    end
    endk = f_edge + 3;
    if (rise_q.size() > 0 && rise_q[rise_q.size()-1] + 4 > endk) endk = rise_q[rise_q.size()-1] + 4;
    obs_arm.delete(); obs_done.delete();
    for (int k = t0; k <= endk; k++) begin
      start_i      = (k == t0) || (k == bs);
      frames_i     = (k == t0) ? 16'(n_fr) : 16'($urandom);
      skip_i       = (k == t0) ? 8'(k_skip) : 8'($urandom);
      timeout_i    = (k == t0) ? 32'(t) : $urandom;
      abort_i      = (k == a);
      cmos_vsync_i = vsync_at(k);
      tick();
      ri = rise_idx(k);
      if (ri >= 0) begin frame_length_i = len_q[ri]; bits_per_frame_i = bits_q[ri]; end
      if (arm_o) obs_arm.push_back(k);
      if (done_o) obs_done.push_back(k);
      if (k == t0) begin
        check_eq("start_clears", 64'({error_o, err_code_o, frames_done_o}), 64'd0);
        check_eq("busy_after_start", 64'(busy_o), 64'd1);
      end
      if (k == f_edge) check_eq("error_at_end", 64'(error_o), 64'(f_err));
      if (k == f_edge + 1) check_eq("busy_released", 64'(busy_o), 64'd0);
    end
    start_i = 1'b0; abort_i = 1'b0; cmos_vsync_i = 1'b0;
    check_eq("arm_count", 64'(obs_arm.size()), 64'(exp_arm.size()));
    for (int i = 0; i < obs_arm.size() && i < exp_arm.size(); i++)
      check_eq("arm_edge", 64'(obs_arm[i]), 64'(exp_arm[i]));
    check_eq("done_count", 64'(obs_done.size()), f_err ? 64'd0 : 64'd1);
    if (!f_err && obs_done.size() > 0) check_eq("done_edge", 64'(obs_done[0]), 64'(f_edge));
    check_eq("error_o", 64'(error_o), 64'(f_err));
    check_eq("err_code_o", 64'(err_code_o), 64'(f_code));
    check_eq("frames_done_o", 64'(frames_done_o), 64'(ns));
    check_eq("last_len_o", 64'(last_len_o), 64'(m_last_len));
    check_eq("last_bits_o", 64'(last_bits_o), 64'(m_last_bits));
`ifdef CC_SCHED_STATS_EN
    check_eq("total_bits_o", 64'(total_bits_o), 64'(m_tot));
    check_eq("max_len_o", 64'(max_len_o), 64'(m_max));
    check_eq("min_len_o", 64'(min_len_o), 64'(m_min));
`endif
  endtask

  initial begin
    repeat (3) tick();
    check_eq("reset_outputs",
             64'({arm_o, busy_o, done_o, error_o, err_code_o, frames_done_o}), 64'd0);
    check_eq("reset_stats", 64'(last_len_o | last_bits_o), 64'd0);
    rst_n = 1'b1;
    tick();

    start_i = 1'b1; abort_i = 1'b1; frames_i = 16'd2;
    tick();
    start_i = 1'b0; abort_i = 1'b0;
    tick();
    check_eq("start_with_abort_ignored", 64'({busy_o, arm_o, done_o}), 64'd0);

    for (int j = 0; j < 40; j++) run_job();

    start_i = 1'b1; frames_i = 16'd3; skip_i = 8'd0; timeout_i = 32'd0;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    cmos_vsync_i = 1'b1;
    tick();
    tick();
    tick();
    check_eq("busy_in_capture", 64'(busy_o), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("async_reset_outputs",
             64'({arm_o, busy_o, done_o, error_o, err_code_o, frames_done_o}), 64'd0);
    check_eq("async_reset_stats", 64'(last_len_o | last_bits_o), 64'd0);
    cmos_vsync_i = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check_eq("idle_after_reset", 64'({busy_o, arm_o, done_o}), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
